// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage and the only driver of the register-file write port.
// It takes retired ALU, link and load results from execute, waits for data-memory responses
// on loads, and issues exactly one registered write per instruction.
// Optional feature macro: WB_BYPASS_EN adds fwd_valid/fwd_reg/fwd_data forwarding outputs.
module writeback_stage #(
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_reg_write,
    input  logic [4:0]        ex_dest,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_is_load,
    input  logic [1:0]        ex_ld_size,
    input  logic              ex_ld_unsigned,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              reg_write,
    output logic [4:0]        write_register,
    output logic [DATA_W-1:0] write_data,
    output logic              wb_busy,
    output logic [4:0]        pending_dest,
    output logic              err_timeout
`ifdef WB_BYPASS_EN
    ,
    output logic              fwd_valid,
    output logic [4:0]        fwd_reg,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    // Last counter value before the abort; the abort happens when the count would reach MEM_TIMEOUT.
    localparam logic [3:0] CNT_LAST = 4'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              reg_write_q, reg_write_d;
    logic [4:0]        write_register_q, write_register_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [4:0]        pending_dest_q, pending_dest_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_unsigned_q, ld_unsigned_d;
    logic              ld_reg_write_q, ld_reg_write_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_timeout_q, err_timeout_d;
    logic              accept;
    logic [DATA_W-1:0] ext_data;

    // Handshake: execute may hand over a new instruction unless a load is outstanding.
    always_comb begin
        ex_ready = (state_q == IDLE) || (state_q == WRITE);
        accept   = ex_valid && ex_ready;
    end

    // Right-aligned load data extended to the datapath width; reserved size 11 behaves as word.
    always_comb begin
        ext_data = mem_rdata;
        case (ld_size_q)
            2'b01:   ext_data = {{(DATA_W-16){(~ld_unsigned_q) & mem_rdata[15]}}, mem_rdata[15:0]};
            2'b10:   ext_data = {{(DATA_W-8){(~ld_unsigned_q) & mem_rdata[7]}}, mem_rdata[7:0]};
            default: ext_data = mem_rdata;
        endcase
    end

    // Next-state and next-output logic for the IDLE / WAIT_MEM / WRITE controller.
    always_comb begin
        state_d          = state_q;
        reg_write_d      = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        pending_dest_d   = pending_dest_q;
        ld_size_d        = ld_size_q;
        ld_unsigned_d    = ld_unsigned_q;
        ld_reg_write_d   = ld_reg_write_q;
        cnt_d            = cnt_q;
        err_timeout_d    = err_timeout_q;

        case (state_q)
            IDLE, WRITE: begin
                if (accept) begin
                    if (ex_is_load) begin
                        state_d        = WAIT_MEM;
                        pending_dest_d = ex_dest;
                        ld_size_d      = ex_ld_size;
                        ld_unsigned_d  = ex_ld_unsigned;
                        ld_reg_write_d = ex_reg_write;
                        cnt_d          = '0;
                    end else begin
                        state_d          = WRITE;
                        reg_write_d      = ex_reg_write && (ex_dest != 5'd0);
                        write_register_d = ex_dest;
                        write_data_d     = ex_result;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_MEM: begin
                // A response arriving on the final timeout cycle still completes the load.
                if (mem_rvalid) begin
                    state_d          = WRITE;
                    reg_write_d      = ld_reg_write_q && (pending_dest_q != 5'd0);
                    write_register_d = pending_dest_q;
                    write_data_d     = ext_data;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d       = IDLE;
                        err_timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
            pending_dest_q   <= '0;
            ld_size_q        <= '0;
            ld_unsigned_q    <= 1'b0;
            ld_reg_write_q   <= 1'b0;
            cnt_q            <= '0;
            err_timeout_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            pending_dest_q   <= pending_dest_d;
            ld_size_q        <= ld_size_d;
            ld_unsigned_q    <= ld_unsigned_d;
            ld_reg_write_q   <= ld_reg_write_d;
            cnt_q            <= cnt_d;
            err_timeout_q    <= err_timeout_d;
        end
    end

    // Output port mapping.
    always_comb begin
        reg_write      = reg_write_q;
        write_register = write_register_q;
        write_data     = write_data_q;
        wb_busy        = (state_q == WAIT_MEM);
        pending_dest   = pending_dest_q;
        err_timeout    = err_timeout_q;
    end

`ifdef WB_BYPASS_EN
    // Forwarding copies of the write port for decode's operand muxes.
    always_comb begin
        fwd_valid = reg_write_q;
        fwd_reg   = write_register_q;
        fwd_data  = write_data_q;
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage with hand-computed expected values.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_reg_write;
    logic [4:0]  ex_dest;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic [1:0]  ex_ld_size;
    logic        ex_ld_unsigned;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        reg_write;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        wb_busy;
    logic [4:0]  pending_dest;
    logic        err_timeout;
`ifdef WB_BYPASS_EN
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    writeback_stage #(.DATA_W(32), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_reg_write(ex_reg_write), .ex_dest(ex_dest), .ex_result(ex_result),
        .ex_is_load(ex_is_load), .ex_ld_size(ex_ld_size), .ex_ld_unsigned(ex_ld_unsigned),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
        .wb_busy(wb_busy), .pending_dest(pending_dest), .err_timeout(err_timeout)
`ifdef WB_BYPASS_EN
        , .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic rw, input logic [4:0] rg, input logic [31:0] d);
        chk({tag, ".reg_write"}, 32'(reg_write), 32'(rw));
        chk({tag, ".write_register"}, 32'(write_register), 32'(rg));
        chk({tag, ".write_data"}, write_data, d);
`ifdef WB_BYPASS_EN
        chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(rw));
        chk({tag, ".fwd_reg"}, 32'(fwd_reg), 32'(rg));
        chk({tag, ".fwd_data"}, fwd_data, d);
`endif
    endtask

    task automatic send_alu(input logic rw, input logic [4:0] dest, input logic [31:0] res);
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_reg_write = rw; ex_dest = dest; ex_result = res;
    endtask

    task automatic send_load(input logic [4:0] dest, input logic [1:0] size, input logic uns);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_dest = dest;
        ex_ld_size = size; ex_ld_unsigned = uns; ex_result = 32'hAAAA_5555;
    endtask

    task automatic drop_valid();
        ex_valid = 1'b0; ex_is_load = 1'b0;
    endtask

    // Load with the response in the first WAIT_MEM cycle.
    task automatic quick_load(input string tag, input logic [4:0] dest, input logic [1:0] size,
                              input logic uns, input logic [31:0] rdata,
                              input logic exp_rw, input logic [31:0] exp_d);
        send_load(dest, size, uns);
        tick();
        drop_valid();
        chk({tag, ".busy"}, 32'(wb_busy), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
        chk_wr(tag, exp_rw, dest, exp_d);
        tick();
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_reg_write = 1'b0; ex_dest = '0; ex_result = '0;
        ex_is_load = 1'b0; ex_ld_size = '0; ex_ld_unsigned = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();

        // Reset state
        chk_wr("reset", 1'b0, 5'd0, 32'd0);
        chk("reset.busy", 32'(wb_busy), 32'd0);
        chk("reset.pending", 32'(pending_dest), 32'd0);
        chk("reset.err", 32'(err_timeout), 32'd0);
        chk("reset.ready", 32'(ex_ready), 32'd1);
        rst = 1'b0;
        tick();

        // 1: single ALU result
        send_alu(1'b1, 5'd5, 32'h0000_002A);
        tick();
        drop_valid();
        chk_wr("alu", 1'b1, 5'd5, 32'h0000_002A);
        chk("alu.ready", 32'(ex_ready), 32'd1);
        tick();
        chk_wr("alu.idle", 1'b0, 5'd5, 32'h0000_002A);

        // 2: back-to-back writes
        send_alu(1'b1, 5'd1, 32'h11);
        tick();
        chk_wr("b2b.first", 1'b1, 5'd1, 32'h11);
        chk("b2b.ready1", 32'(ex_ready), 32'd1);
        send_alu(1'b1, 5'd2, 32'h22);
        tick();
        drop_valid();
        chk_wr("b2b.second", 1'b1, 5'd2, 32'h22);
        chk("b2b.ready2", 32'(ex_ready), 32'd1);
        tick();
        chk("b2b.done", 32'(reg_write), 32'd0);

        // Writes to r0 and non-writing instructions
        send_alu(1'b1, 5'd0, 32'h55);
        tick();
        drop_valid();
        chk_wr("alu.r0", 1'b0, 5'd0, 32'h55);
        send_alu(1'b0, 5'd7, 32'h77);
        tick();
        drop_valid();
        chk_wr("alu.nowrite", 1'b0, 5'd7, 32'h77);
        tick();

        // 3: signed byte load, response after 4 WAIT_MEM cycles
        send_load(5'd3, 2'b10, 1'b0);
        tick();
        drop_valid();
        for (int i = 0; i < 4; i++) begin
            chk("lb.busy", 32'(wb_busy), 32'd1);
            chk("lb.pending", 32'(pending_dest), 32'd3);
            chk("lb.ready", 32'(ex_ready), 32'd0);
            chk("lb.nowrite", 32'(reg_write), 32'd0);
            if (i < 3) tick();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0080;
        tick();
        mem_rvalid = 1'b0;
        chk_wr("lb.signed", 1'b1, 5'd3, 32'hFFFF_FF80);
        chk("lb.busy_off", 32'(wb_busy), 32'd0);
        tick();
        chk("lb.single", 32'(reg_write), 32'd0);

        // 3b/4 and other sizes
        quick_load("lbu", 5'd3, 2'b10, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080);
        quick_load("lh.r0", 5'd0, 2'b01, 1'b0, 32'h1234_8001, 1'b0, 32'hFFFF_8001);
        quick_load("lhu", 5'd6, 2'b01, 1'b1, 32'h1234_8001, 1'b1, 32'h0000_8001);
        quick_load("lw", 5'd8, 2'b00, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
        quick_load("lres", 5'd9, 2'b11, 1'b1, 32'h8765_4321, 1'b1, 32'h8765_4321);

        // Stray mem_rvalid while idle
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        chk_wr("stray", 1'b0, 5'd9, 32'h8765_4321);
        chk("stray.ready", 32'(ex_ready), 32'd1);

        // 5: timeout after 15 cycles
        send_load(5'd10, 2'b00, 1'b0);
        tick();
        drop_valid();
        for (int i = 1; i <= 15; i++) begin
            chk("to.busy", 32'(wb_busy), 32'd1);
            chk("to.err_low", 32'(err_timeout), 32'd0);
            tick();
        end
        chk("to.busy_off", 32'(wb_busy), 32'd0);
        chk("to.err", 32'(err_timeout), 32'd1);
        chk("to.ready", 32'(ex_ready), 32'd1);
        chk("to.nowrite", 32'(reg_write), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        chk_wr("to.late", 1'b0, 5'd9, 32'h8765_4321);
        send_alu(1'b1, 5'd4, 32'h44);
        tick();
        drop_valid();
        chk_wr("to.alu", 1'b1, 5'd4, 32'h44);
        chk("to.sticky", 32'(err_timeout), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to.rst_clear", 32'(err_timeout), 32'd0);
        tick();

        // Response on the final timeout cycle completes the load
        send_load(5'd11, 2'b00, 1'b0);
        tick();
        drop_valid();
        for (int i = 1; i < 15; i++) tick();
        chk("edge.busy", 32'(wb_busy), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_CAFE;
        tick();
        mem_rvalid = 1'b0;
        chk_wr("edge.write", 1'b1, 5'd11, 32'h0BAD_CAFE);
        chk("edge.err", 32'(err_timeout), 32'd0);
        tick();

        // 6: reset while waiting, then late response
        send_load(5'd12, 2'b00, 1'b0);
        tick();
        drop_valid();
        chk("rstw.busy", 32'(wb_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_wr("rstw.reset", 1'b0, 5'd0, 32'd0);
        chk("rstw.busy_off", 32'(wb_busy), 32'd0);
        chk("rstw.pending", 32'(pending_dest), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        tick();
        mem_rvalid = 1'b0;
        chk_wr("rstw.late", 1'b0, 5'd0, 32'd0);
        chk("rstw.busy2", 32'(wb_busy), 32'd0);
        chk("rstw.err", 32'(err_timeout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
